ap_cpu_mem_arbiter_16: RTL and testbench

//  Shares one 16-bit-data memory between two 32-bit CPU requesters: port I (fetch) and port D (load/store).

---
 rtl/ap_cpu_mem_arbiter_16.sv | 195 +++++++++++++++++++
 tb/tb_ap_cpu_mem_arbiter_16.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_cpu_mem_arbiter_16.sv
// ---------------------------------------------------------------------------
// ap_cpu_mem_arbiter_16
//
// Purpose:
//   Shares one 16-bit-data memory between two 32-bit CPU requesters, port I
//   (instruction fetch) and port D (load/store). One request is granted at a
//   time. Each 32-bit access is then run as two 16-bit memory beats, high half
//   first. All outputs are registered.
//
// Configuration:
//   AP_ARB_ROUND_ROBIN_EN
//     Defined:   when both ports request together, the port not granted last
//                wins. D_PRIORITY is ignored.
//     Undefined: fixed priority set by D_PRIORITY. A winner that keeps
//                requesting can starve the other port.
//
// Parameters:
//   ADDR_WIDTH  CPU word-address width. The memory address has the same width.
//   D_PRIORITY  Fixed-priority mode only. 1 = D wins ties, 0 = I wins ties.
//
// Ports:
//   iCLK, iRESETn             clock (rising edge) and asynchronous active-low reset
//   iX_EN / iX_RW             request and direction (1 = write), X in {I, D}
//   iX_ADDR / iX_WDATA        word address and write data
//   oX_RDY / oX_RDATA         access done (a level, held until EN drops) and read data
//   oMEM_EN / oMEM_RW         memory beat request and direction
//   oMEM_ADDR / oMEM_WDATA    halfword address (word*2 + half) and beat write data
//   iMEM_RDATA / iMEM_RDY     beat read data and beat accepted
// ---------------------------------------------------------------------------
module ap_cpu_mem_arbiter_16 #(
    parameter int ADDR_WIDTH = 32,
    parameter bit D_PRIORITY = 1'b1
) (
    input  logic                  iCLK,
    input  logic                  iRESETn,
    input  logic                  iI_EN,
    input  logic                  iI_RW,
    input  logic [ADDR_WIDTH-1:0] iI_ADDR,
    input  logic [31:0]           iI_WDATA,
    input  logic                  iD_EN,
    input  logic                  iD_RW,
    input  logic [ADDR_WIDTH-1:0] iD_ADDR,
    input  logic [31:0]           iD_WDATA,
    output logic                  oI_RDY,
    output logic [31:0]           oI_RDATA,
    output logic                  oD_RDY,
    output logic [31:0]           oD_RDATA,
    output logic                  oMEM_EN,
    output logic                  oMEM_RW,
    output logic [ADDR_WIDTH-1:0] oMEM_ADDR,
    output logic [15:0]           oMEM_WDATA,
    input  logic [15:0]           iMEM_RDATA,
    input  logic                  iMEM_RDY
);

    typedef enum logic [1:0] {ST_IDLE, ST_HI, ST_LO, ST_DONE} state_t;

    state_t                state_q;
    logic                  grant_d_q;   // 1 = current access belongs to port D
    logic                  rw_q;
    logic [ADDR_WIDTH-2:0] addr_q;      // top CPU address bit is dropped (wraps)
    logic [31:0]           wdata_q;
    logic                  abort_q;     // winner dropped EN mid-access
    logic                  mem_en_q, mem_rw_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [15:0]           mem_wdata_q;
    logic                  i_rdy_q, d_rdy_q;
    logic [31:0]           i_rdata_q, d_rdata_q;
`ifdef AP_ARB_ROUND_ROBIN_EN
    logic                  last_d_q;    // 1 = last grant went to port D
`endif

    // Arbitration decision and the winner's request fields, used in IDLE only
    logic                  grant_d_d;
    logic                  sel_rw;
    logic [ADDR_WIDTH-2:0] sel_addr;
    logic [31:0]           sel_wdata;
    logic                  win_en;

    // NOTE: every output of an always_comb gets a default first, so no path
    // can leave it unassigned and infer a latch.
    always_comb begin
        grant_d_d = 1'b0;
        if (iD_EN && !iI_EN) begin
            grant_d_d = 1'b1;
        end else if (iD_EN && iI_EN) begin
`ifdef AP_ARB_ROUND_ROBIN_EN
            grant_d_d = !last_d_q;
`else
            grant_d_d = D_PRIORITY;
`endif
        end
        sel_rw    = grant_d_d ? iD_RW : iI_RW;
        sel_addr  = grant_d_d ? iD_ADDR[ADDR_WIDTH-2:0] : iI_ADDR[ADDR_WIDTH-2:0];
        sel_wdata = grant_d_d ? iD_WDATA : iI_WDATA;
    end

    assign win_en = grant_d_q ? iD_EN : iI_EN;

    // The address MSBs are discarded on purpose: halfword addressing wraps.
    logic unused_addr_msb;
    assign unused_addr_msb = &{1'b0, iI_ADDR[ADDR_WIDTH-1], iD_ADDR[ADDR_WIDTH-1]};

    // NOTE: sequential state uses non-blocking assignments only. Every register
    // then updates from pre-edge values, with no ordering races.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state_q     <= ST_IDLE;
            grant_d_q   <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            abort_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdy_q     <= 1'b0;
            d_rdy_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
`ifdef AP_ARB_ROUND_ROBIN_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (iI_EN || iD_EN) begin
                        grant_d_q   <= grant_d_d;
                        rw_q        <= sel_rw;
                        addr_q      <= sel_addr;
                        wdata_q     <= sel_wdata;
                        abort_q     <= 1'b0;
                        mem_en_q    <= 1'b1;
                        mem_rw_q    <= sel_rw;
                        mem_addr_q  <= {sel_addr, 1'b0};
                        mem_wdata_q <= sel_wdata[31:16];
                        state_q     <= ST_HI;
`ifdef AP_ARB_ROUND_ROBIN_EN
                        last_d_q    <= grant_d_d;
`endif
                    end
                end
                ST_HI: begin
                    if (!win_en) abort_q <= 1'b1;
                    if (iMEM_RDY) begin
                        if (!rw_q) begin
                            if (grant_d_q) d_rdata_q[31:16] <= iMEM_RDATA;
                            else           i_rdata_q[31:16] <= iMEM_RDATA;
                        end
                        mem_addr_q  <= {addr_q, 1'b1};
                        mem_wdata_q <= wdata_q[15:0];
                        state_q     <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (iMEM_RDY) begin
                        if (!rw_q) begin
                            if (grant_d_q) d_rdata_q[15:0] <= iMEM_RDATA;
                            else           i_rdata_q[15:0] <= iMEM_RDATA;
                        end
                        mem_en_q <= 1'b0;
                        // Both beats always run, so a write is never torn.
                        // An abandoned access skips the handshake.
                        if (abort_q || !win_en) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_DONE;
                            if (grant_d_q) d_rdy_q <= 1'b1;
                            else           i_rdy_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!win_en) begin
                        i_rdy_q <= 1'b0;
                        d_rdy_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign oI_RDY     = i_rdy_q;
    assign oI_RDATA   = i_rdata_q;
    assign oD_RDY     = d_rdy_q;
    assign oD_RDATA   = d_rdata_q;
    assign oMEM_EN    = mem_en_q;
    assign oMEM_RW    = mem_rw_q;
    assign oMEM_ADDR  = mem_addr_q;
    assign oMEM_WDATA = mem_wdata_q;

endmodule

// File: tb/tb_ap_cpu_mem_arbiter_16.sv
// ---------------------------------------------------------------------------
// tb_ap_cpu_mem_arbiter_16
//
// Directed testbench for ap_cpu_mem_arbiter_16.
//
// The bench keeps its own picture of the expected behaviour:
//   - a halfword memory array;
//   - a queue of the memory beats each request must produce, pushed in the
//     order the arbitration rules say the requests are served;
//   - the read data each port must show.
// A negedge process compares the DUT against this picture on every cycle.
// The directed sequences also check literal values.
// ---------------------------------------------------------------------------
module tb_ap_cpu_mem_arbiter_16;

    localparam int AW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          i_en = 1'b0, i_rw = 1'b0, d_en = 1'b0, d_rw = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [31:0]   i_wdata = '0, d_wdata = '0;
    logic          mem_rdy = 1'b1;
    logic          i_rdy, d_rdy, mem_en, mem_rw;
    logic [31:0]   i_rdata, d_rdata;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;

    ap_cpu_mem_arbiter_16 #(.ADDR_WIDTH(AW), .D_PRIORITY(1'b1)) dut (
        .iCLK(clk), .iRESETn(rst_n),
        .iI_EN(i_en), .iI_RW(i_rw), .iI_ADDR(i_addr), .iI_WDATA(i_wdata),
        .iD_EN(d_en), .iD_RW(d_rw), .iD_ADDR(d_addr), .iD_WDATA(d_wdata),
        .oI_RDY(i_rdy), .oI_RDATA(i_rdata), .oD_RDY(d_rdy), .oD_RDATA(d_rdata),
        .oMEM_EN(mem_en), .oMEM_RW(mem_rw), .oMEM_ADDR(mem_addr), .oMEM_WDATA(mem_wdata),
        .iMEM_RDATA(mem_rdata), .iMEM_RDY(mem_rdy)
    );

    // ---------------- memory model ----------------
    logic [15:0] mem [0:255];
    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (rst_n && mem_en && mem_rdy && mem_rw) mem[mem_addr[7:0]] <= mem_wdata;
    end

    // ---------------- reference picture ----------------
    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [15:0] wdata;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] exp_rd_i = '0, exp_rd_d = '0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the two beats a request must produce. For a read, also record the
    // word the port must return.
    task automatic push_req(input bit pd, input bit rw, input logic [31:0] addr,
                            input logic [31:0] wd);
        logic [31:0] ha;
        beat_t       b;
        ha = {addr[30:0], 1'b0};
        b.addr = ha;        b.rw = rw; b.wdata = wd[31:16]; exp_q.push_back(b);
        b.addr = ha | 32'd1; b.rw = rw; b.wdata = wd[15:0]; exp_q.push_back(b);
        if (!rw) begin
            if (pd) exp_rd_d = {mem[ha[7:0]], mem[ha[7:0] | 8'd1]};
            else    exp_rd_i = {mem[ha[7:0]], mem[ha[7:0] | 8'd1]};
        end
    endtask

    // Per-cycle comparison against the reference picture.
    always @(negedge clk) begin
        if (rst_n) begin
            check("rdy_exclusive", {31'b0, i_rdy & d_rdy}, 32'd0);
            if (i_rdy) begin
                check("i_rdata", i_rdata, exp_rd_i);
                check("d_rdata_hold", d_rdata, exp_rd_d);
            end
            if (d_rdy) begin
                check("d_rdata", d_rdata, exp_rd_d);
                check("i_rdata_hold", i_rdata, exp_rd_i);
            end
            if (mem_en) begin
                check("beat_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    check("beat_addr", mem_addr, exp_q[0].addr);
                    check("beat_rw", {31'b0, mem_rw}, {31'b0, exp_q[0].rw});
                    if (exp_q[0].rw) check("beat_wdata", {16'b0, mem_wdata}, {16'b0, exp_q[0].wdata});
                    if (mem_rdy) void'(exp_q.pop_front());
                end
            end
        end
    end

    // One complete access on one port, with an optional stall in HI.
    task automatic access(input bit pd, input bit rw, input logic [31:0] addr,
                          input logic [31:0] wd, input int stall, input int exp_lat,
                          input string nm);
        int lat;
        bit got;
        push_req(pd, rw, addr, wd);
        mem_rdy = (stall == 0);
        if (pd) begin d_rw = rw; d_addr = addr; d_wdata = wd; d_en = 1'b1; end
        else    begin i_rw = rw; i_addr = addr; i_wdata = wd; i_en = 1'b1; end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            tick();
            lat++;
            if (lat == 1 + stall) mem_rdy = 1'b1;
            got = pd ? d_rdy : i_rdy;
        end
        check({nm, "_latency"}, lat, exp_lat);
        check({nm, "_other_rdy"}, {31'b0, pd ? i_rdy : d_rdy}, 32'd0);
        if (pd) d_en = 1'b0; else i_en = 1'b0;
        tick();
        check({nm, "_rdy_release"}, {31'b0, pd ? d_rdy : i_rdy}, 32'd0);
    endtask

    bit order [4];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 16'h0;
        tick();
        mem[8'h20] <= 16'hDEAD; mem[8'h21] <= 16'hBEEF;
        mem[8'h60] <= 16'hCAFE; mem[8'h61] <= 16'hF00D;
        tick();
        // Reset state
        check("rst_mem_en", {31'b0, mem_en}, 32'd0);
        check("rst_rdy", {30'b0, i_rdy, d_rdy}, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: D read of word 0x10. Minimum latency is three edges.
        access(1'b1, 1'b0, 32'h10, 32'h0, 0, 3, "t1");
        check("t1_rdata", d_rdata, 32'hDEADBEEF);

        // 2: I write of word 0x4. The I read data must stay unchanged.
        access(1'b0, 1'b1, 32'h4, 32'h12345678, 0, 3, "t2");
        check("t2_mem_hi", {16'b0, mem[8'h08]}, 32'h1234);
        check("t2_mem_lo", {16'b0, mem[8'h09]}, 32'h5678);
        check("t2_i_rdata", i_rdata, 32'h0);

        // 3: contention. D keeps re-requesting and I holds its request.
`ifdef AP_ARB_ROUND_ROBIN_EN
        order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        mem_rdy = 1'b1;
        d_rw = 1'b0; d_addr = 32'h10; i_rw = 1'b0; i_addr = 32'h30;
        for (int k = 0; k < 4; k++) begin
            int n;
            push_req(order[k], 1'b0, order[k] ? 32'h10 : 32'h30, 32'h0);
            if (k == 0) begin d_en = 1'b1; i_en = 1'b1; end
            n = 0;
            while (!(i_rdy || d_rdy) && n < 60) begin tick(); n++; end
            check("t3_winner_d", {31'b0, d_rdy}, {31'b0, order[k]});
            check("t3_winner_i", {31'b0, i_rdy}, {31'b0, !order[k]});
            if (order[k]) d_en = 1'b0; else i_en = 1'b0;
            tick();
            if (k < 3) begin
                if (order[k]) d_en = 1'b1; else i_en = 1'b1;
            end
        end
        begin
            bit fp;
            int n;
            fp = !order[3];
            push_req(fp, 1'b0, fp ? 32'h10 : 32'h30, 32'h0);
            n = 0;
            while (!(fp ? d_rdy : i_rdy) && n < 60) begin tick(); n++; end
            check("t3_final_rdy", {31'b0, fp ? d_rdy : i_rdy}, 32'd1);
            d_en = 1'b0; i_en = 1'b0;
            tick();
            tick();
        end

        // 4: I read with 4 stall cycles in HI. Latency grows from 3 to 7.
        access(1'b0, 1'b0, 32'h30, 32'h0, 4, 7, "t4");
        check("t4_rdata", i_rdata, 32'hCAFEF00D);

        // 5: D write abandoned during HI. Both beats still complete, no RDY.
        push_req(1'b1, 1'b1, 32'h40, 32'hA5A55A5A);
        mem_rdy = 1'b0;
        d_rw = 1'b1; d_addr = 32'h40; d_wdata = 32'hA5A55A5A; d_en = 1'b1;
        tick();
        d_en = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        for (int n = 0; n < 7; n++) begin
            tick();
            if (n == 1) mem_rdy = 1'b1;
            check("t5_no_rdy", {31'b0, d_rdy}, 32'd0);
        end
        check("t5_idle_mem_en", {31'b0, mem_en}, 32'd0);
        check("t5_beats_done", exp_q.size(), 32'd0);
        check("t5_mem_hi", {16'b0, mem[8'h80]}, 32'hA5A5);
        check("t5_mem_lo", {16'b0, mem[8'h81]}, 32'h5A5A);

        // 6: reset while in LO, then a fresh request.
        push_req(1'b0, 1'b0, 32'h30, 32'h0);
        i_rw = 1'b0; i_addr = 32'h30; i_en = 1'b1;
        tick();
        tick();
        check("t6_lo_addr", mem_addr, 32'h61);
        rst_n = 1'b0;
        #1;
        check("t6_rst_mem_en", {31'b0, mem_en}, 32'd0);
        check("t6_rst_rdy", {30'b0, i_rdy, d_rdy}, 32'd0);
        check("t6_rst_rdata", i_rdata | d_rdata, 32'd0);
        exp_q.delete();
        i_en = 1'b0;
        exp_rd_i = '0;
        exp_rd_d = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        access(1'b1, 1'b0, 32'h10, 32'h0, 0, 3, "t6_fresh");
        check("t6_fresh_rdata", d_rdata, 32'hDEADBEEF);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
